// File: rtl/fp_cmp_seq.sv
// rtl/fp_cmp_seq.sv - single-precision compare/min/max sequencer with RISC-V NaN and signed-zero handling
module fp_cmp_seq #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] CANON_NAN  = 32'h7FC00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_numA,
  input  logic [DATA_WIDTH-1:0] in_numB,
  output logic [DATA_WIDTH-1:0] out_cmp_numA,
  output logic [DATA_WIDTH-1:0] out_cmp_numB,
  output logic [1:0]            out_cmp_type,
  input  logic [63:0]           in_cmp_result,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [63:0]           out_data,
  output logic                  out_flag_NV,
  input  logic                  in_flag_clr,
  output logic                  out_fflag_NV
);

  localparam logic [2:0] OP_FLE  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FEQ  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b100;
  localparam logic [2:0] OP_FMAX = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_SEL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  lt_q, lt_d;
  logic [63:0]           data_q, data_d;
  logic                  nv_q, nv_d;
  logic                  fflag_q, fflag_d;

  logic                  nan_a, nan_b, snan_a, snan_b, zero_a, zero_b;
  logic                  any_nan, any_snan, both_zero, is_minmax, handshake;
  logic [DATA_WIDTH-1:0] mm_res;
  logic                  unused_cmp_hi;

  assign unused_cmp_hi = ^in_cmp_result[63:1];

  assign nan_a     = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign nan_b     = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
  assign snan_a    = nan_a && !a_q[22];
  assign snan_b    = nan_b && !b_q[22];
  assign zero_a    = (a_q[30:0] == 31'd0);
  assign zero_b    = (b_q[30:0] == 31'd0);
  assign any_nan   = nan_a || nan_b;
  assign any_snan  = snan_a || snan_b;
  assign both_zero = zero_a && zero_b;
  assign is_minmax = (op_q == OP_FMIN) || (op_q == OP_FMAX);
  assign handshake = (state_q == S_DONE) && in_ready;

  // Mixed-sign zeros are ordered by hand: the datapath treats -0 == +0.
  always_comb begin
    mm_res = '0;
    if (nan_a && nan_b) begin
      mm_res = CANON_NAN;
    end else if (nan_a) begin
      mm_res = b_q;
    end else if (nan_b) begin
      mm_res = a_q;
    end else if (both_zero && (a_q[31] != b_q[31])) begin
      mm_res = op_q[0] ? '0 : {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else if (op_q[0]) begin
      mm_res = lt_q ? b_q : a_q;
    end else begin
      mm_res = lt_q ? a_q : b_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      lt_q    <= 1'b0;
      data_q  <= 64'd0;
      nv_q    <= 1'b0;
      fflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lt_q    <= lt_d;
      data_q  <= data_d;
      nv_q    <= nv_d;
      fflag_q <= fflag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_CMP;
      S_CMP:   state_d = is_minmax ? S_SEL : S_DONE;
      S_SEL:   state_d = S_DONE;
      S_DONE:  if (in_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    lt_d    = lt_q;
    data_d  = data_q;
    nv_d    = nv_q;
    fflag_d = (fflag_q && !in_flag_clr) || (handshake && nv_q);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = in_op;
          a_d  = in_numA;
          b_d  = in_numB;
        end
      end
      S_CMP: begin
        case (op_q)
          OP_FEQ: begin
            data_d = {63'd0, !any_nan && (both_zero || in_cmp_result[0])};
            nv_d   = any_snan;
          end
          OP_FLT: begin
            data_d = {63'd0, !any_nan && !both_zero && in_cmp_result[0]};
            nv_d   = any_nan;
          end
          OP_FLE: begin
            data_d = {63'd0, !any_nan && (both_zero || in_cmp_result[0])};
            nv_d   = any_nan;
          end
          OP_FMIN, OP_FMAX: lt_d = in_cmp_result[0];
          default: begin
            data_d = 64'd0;
            nv_d   = 1'b0;
          end
        endcase
      end
      S_SEL: begin
        data_d = {{(64-DATA_WIDTH){1'b1}}, mm_res};
        nv_d   = any_snan;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_ready    = (state_q == S_IDLE);
    out_valid    = (state_q == S_DONE);
    out_cmp_type = (op_q == OP_FEQ) ? 2'b10 : (op_q == OP_FLE) ? 2'b00 : 2'b01;
  end

  assign out_cmp_numA = a_q;
  assign out_cmp_numB = b_q;
  assign out_data     = data_q;
  assign out_flag_NV  = nv_q;
  assign out_fflag_NV = fflag_q;

endmodule

// File: doc/fp_cmp_seq.md
Name: fp_cmp_seq

Overview:
- Sequencer that sits between the FP issue stage and the single-precision compare datapath.
- Accepts one FEQ/FLT/FLE/FMIN/FMAX op at a time over a valid/ready handshake.
- Registers operands and drives the compare datapath, then adds RISC-V NaN and signed-zero qualification; FMIN/FMAX take an extra select cycle.
- Returns a 64-bit writeback value plus a per-op NV flag, and keeps a sticky NV accumulator for fflags.

Parameters:
- DATA_WIDTH, 32, operand width (single precision only).
- CANON_NAN, 32'h7FC00000, canonical quiet NaN returned by FMIN/FMAX when both inputs are NaN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  op request valid.
- out_ready  out  1  sequencer can accept an op; high only in IDLE.
- in_op  in  3  000 FLE, 001 FLT, 010 FEQ, 100 FMIN, 101 FMAX; all other codes illegal.
- in_numA, in_numB  in  DATA_WIDTH  operands.
- out_cmp_numA, out_cmp_numB  out  DATA_WIDTH  registered operands driven to the compare datapath.
- out_cmp_type  out  2  compare type to datapath: 10 EQ, 01 LT, 00 LE.
- in_cmp_result  in  64  datapath result; only bit 0 is used. Combinational, same cycle.
- out_valid  out  1  result valid.
- in_ready  in  1  consumer accepts the result.
- out_data  out  64  writeback value.
- out_flag_NV  out  1  NV flag for the result currently presented.
- in_flag_clr  in  1  clears the sticky flag.
- out_fflag_NV  out  1  sticky NV accumulator.

Behaviour:
- Reset (async, rst=1): state IDLE, out_ready=1, out_valid=0, out_data=0, out_flag_NV=0, out_fflag_NV=0, out_cmp_* =0.
- Operand classification:
  - NaN = exp==8'hFF and mant!=0.
  - sNaN = NaN and mant[22]==0.
  - Zero = bits[30:0]==0.
- FSM states and transitions:
  - IDLE: on in_valid, capture in_op/in_numA/in_numB, go to CMP. While not in IDLE, in_valid is ignored.
  - CMP: drive registered operands to the datapath.
    - cmp_type = 10 for FEQ, 00 for FLE, 01 for FLT/FMIN/FMAX.
    - For compare ops and illegal codes, compute and register the result/flag, then go to DONE.
    - For FMIN/FMAX, register lt=in_cmp_result[0], then go to SEL.
  - SEL (FMIN/FMAX only): compute the min/max result (rules below), register it, go to DONE.
  - DONE: out_valid=1. Hold out_data and out_flag_NV stable until in_ready; on in_ready go to IDLE.
- Latency:
  - Compare op accepted at edge 0 gives out_valid after edge 2.
  - FMIN/FMAX give out_valid after edge 3.
  - With in_ready tied 1, the next op can be accepted the cycle after out_valid: throughput 1 op per 3 cycles for compares, 1 per 4 for min/max.
- Compare result, zero-extended to 64 bits:
  - Either operand NaN: result 0.
  - Both zero: FEQ=1, FLT=0, FLE=1, regardless of sign.
  - Otherwise: in_cmp_result[0].
- Compare NV:
  - FEQ: set if either operand is sNaN.
  - FLT/FLE: set if either operand is NaN.
- FMIN/FMAX result:
  - Both NaN: CANON_NAN.
  - Exactly one NaN: the other operand.
  - Both zero with different signs: FMIN returns -0 (32'h80000000), FMAX returns +0.
  - Otherwise: FMIN returns lt?A:B, FMAX returns lt?B:A.
  - out_data = {32'hFFFFFFFF, result} (NaN-boxed).
  - NV set if either operand is sNaN.
- Illegal in_op: completes through CMP and DONE with out_data=0 and NV=0.
- Sticky flag:
  - Set on the DONE handshake cycle (out_valid and in_ready) when out_flag_NV=1.
  - in_flag_clr clears it.
  - If set and clear occur in the same cycle, the flag ends at 1.
- Reset mid-operation: the in-flight op is dropped, no out_valid is produced, and the sticky flag is cleared.

Test Plan:
- FLT A=0x3F800000 (1.0), B=0x40000000 (2.0), in_ready=1 -> out_data=1, out_flag_NV=0, out_valid exactly 2 cycles after acceptance; out_ready low during CMP and DONE.
- FEQ A=0x7FC00000 (qNaN), B=0x3F800000 -> out_data=0, out_flag_NV=0. Repeat as FLE -> out_data=0, NV=1, out_fflag_NV=1.
- FMIN A=0x80000000 (-0), B=0x00000000 (+0) -> out_data=0xFFFFFFFF80000000. FMAX of same -> 0xFFFFFFFF00000000. Both ops have 3-cycle latency.
- FMAX A=0x7F800001 (sNaN), B=0x40400000 -> out_data=0xFFFFFFFF40400000, NV=1. Both operands NaN -> 0xFFFFFFFF7FC00000.
- Hold in_ready=0 for 5 cycles in DONE -> out_data and out_flag_NV stable, in_valid ignored. Raise in_flag_clr in the same cycle as an NV-setting handshake -> out_fflag_NV=1. Clear alone on the next cycle -> 0.
- Assert rst during SEL -> all outputs at reset values immediately (async). After release, a new FEQ 2.0/2.0 returns 1.
